// File: rtl/uart_tx_sched.sv
// Round-robin scheduler in front of a single UART transmitter: baud tick generation,
// request arbitration and the start/ready handshake that hands one byte at a time over.
module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int CLK_DIV = 868
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       tx_tick,
  input  logic                       tx_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int          IDW  = $clog2(NUM_REQ);
  localparam int          CW   = $clog2(CLK_DIV);
  localparam int unsigned NREQ = NUM_REQ;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

  typedef enum logic {ARB, SEND} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  tick_cnt;
  logic [IDW-1:0] rr_ptr;
  logic           tx_ready_q;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [7:0]     win_data;
  logic [IDW-1:0] idx;
  logic           grant_en;

  // Free-running baud divider, independent of the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == DIV_MAX) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tx_tick = (tick_cnt == DIV_MAX);

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_data  = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
        win_data  = req_data[{idx, 3'b000} +: 8];
      end
    end
  end

  // The transmitter only drops ready when it takes a start, so a registered
  // high-to-low transition of ready while SEND is the proof the byte was accepted.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    case (state_q)
      ARB: begin
        if (win_found) begin
          grant_en = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (tx_ready_q && !tx_ready) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      rr_ptr     <= '0;
      tx_data    <= '0;
      grant_id   <= '0;
      req_ack    <= '0;
      tx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_ready_q <= tx_ready;
      req_ack    <= '0;
      if (grant_en) begin
        tx_data         <= win_data;
        grant_id        <= win_id;
        req_ack[win_id] <= 1'b1;
        rr_ptr          <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
      end
    end
  end

  assign tx_start = (state_q == SEND);
  assign busy     = (state_q == SEND);

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares the single UART transmitter among NUM_REQ byte sources using round-robin arbitration.
- Generates the transmitter's baud "tick" enable from the system clock.
- Sequences the transmitter's start/ready handshake: holds TxD_data/TxD_start stable until the transmitter has provably taken the byte.
- Sits between the bus-side UART register/FIFO logic and the transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLK_DIV, 868, clock cycles per baud tick (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high. Also fed to the transmitter.
- req_valid  in  NUM_REQ  requester i has a byte; held high until its ack.
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_ack  out  NUM_REQ  one-cycle pulse: requester i's byte captured.
- tx_tick  out  1  baud enable to the transmitter.
- tx_ready  in  1  transmitter ready (idle or in stop bit).
- tx_data  out  8  byte to the transmitter.
- tx_start  out  1  transmission request to the transmitter.
- grant_id  out  clog2(NUM_REQ)  index of the byte currently held or sent.
- busy  out  1  high while in SEND.

Behaviour:
- Reset (async, while rst=1):
  - state=ARB; tick counter=0; rr pointer=0.
  - tx_tick=0, tx_start=0, tx_data=0, grant_id=0, req_ack=0, busy=0.
  - tx_ready_q=0 (registered copy of tx_ready).
- Tick divider:
  - Free-running counter 0..CLK_DIV-1, width clog2(CLK_DIV).
  - tx_tick=1 for exactly one cycle when counter==CLK_DIV-1; counter then wraps to 0.
  - Period is exactly CLK_DIV cycles, independent of state.
- Round-robin arbitration:
  - Search indices ptr, ptr+1, ... mod NUM_REQ; the first i with req_valid[i]=1 wins.
  - After a grant to i, ptr <= (i+1) mod NUM_REQ.
  - Pointer is unchanged when there is no grant.
- FSM state ARB:
  - tx_start=0.
  - If any req_valid is set, on that clock edge: tx_data<=winner's byte, grant_id<=winner, req_ack[winner]<=1 (registered, visible in the first SEND cycle only), state<=SEND.
  - Otherwise stay in ARB.
- FSM state SEND:
  - tx_start=1; tx_data and grant_id held constant.
  - Accept is detected when tx_ready_q==1 && tx_ready==0 while in SEND; on that cycle state<=ARB and tx_start drops on the next cycle.
  - Rationale: the transmitter only deasserts ready when it takes a start, in two cases:
    - From idle: the next cycle.
    - From the stop bit: on a tick.
  - A stop-bit tick without a start leaves ready high, so it is never mistaken for an accept.
  - SEND entered while the transmitter is mid-frame (ready=0) waits for ready to rise, then fall.
- Latency:
  - Idle transmitter: capture edge C; tx_start high from C+1; ready falls at C+2; ARB again at C+3.
  - Back-to-back: the next byte is captured during the current frame and accepted at the STOP→START tick, so there is no idle gap on TxD.
- Requester contract:
  - req_data must be stable while req_valid=1 and until req_ack is seen.
  - req_valid must deassert no later than the cycle after req_ack if there is no further byte.
  - A requester that keeps valid high is treated as having another byte.
- Simultaneous events:
  - All requesters valid: strict rotation.
  - req_valid dropping during SEND has no effect; the captured byte is still sent.
- Reset mid-SEND:
  - tx_start drops immediately; the held byte is discarded with no second ack.
  - The transmitter returns to idle via the same rst.
- busy = (state==SEND).

Test Plan:
1. CLK_DIV=4, only req_valid[0]=1 with data 0xA5, transmitter idle → req_ack[0] pulse 1 cycle after capture; tx_start high until tx_ready falls; TxD frame 0,1,0,1,0,0,1,0,1,1 each lasting 4 cycles; busy low afterwards.
2. All 4 valid (0x11,0x22,0x33,0x44), held until acked, then reasserted with new bytes → grant_id sequence 0,1,2,3,0; each requester acked exactly once per grant.
3. Back-to-back: req 2 sends 0x55 then 0xAA while its first frame runs → second byte accepted at the STOP tick; TxD high for exactly one tick period between frames; no gap cycles.
4. Tick check: CLK_DIV=5, observe 20 cycles after reset → tx_tick high at cycles 4,9,14,19 only.
5. Assert rst asynchronously mid-SEND, between clock edges → tx_start, busy, req_ack go 0 immediately; after release, the next grant starts from requester 0; no duplicate ack.
6. req_valid[1] dropped during SEND of 0x3C → 0x3C is still transmitted; FSM returns to ARB; no grant to requester 1 afterwards.
